// File: rtl/mod53_horner_reduce.sv
// mod53_horner_reduce: folds MSB-first 6-bit chunks into a residue mod 53 (r <- 11*r + c mod 53)
module mod53_horner_reduce #(
  parameter int NUM_CHUNKS = 84
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_res,
  output logic       out_err
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t state, state_next;
  logic [5:0] r, r_next;
  logic [7:0] cnt;
  logic [9:0] t0, t1, t2, t3, t4;
  logic acc, at_end, frame_end;
  assign acc = in_valid & in_ready;
  assign at_end = cnt == 8'(NUM_CHUNKS - 1);
  assign frame_end = in_last | at_end;
  // 11*r as shift-add; first chunk of a frame ignores r. Max sum 635 folds in four binary-weighted steps.
  always_comb begin
    t0 = (cnt == 8'd0 ? 10'd0 : (10'(r) << 3) + (10'(r) << 1) + 10'(r)) + 10'(in_data);
    t1 = t0 >= 10'd424 ? t0 - 10'd424 : t0;
    t2 = t1 >= 10'd212 ? t1 - 10'd212 : t1;
    t3 = t2 >= 10'd106 ? t2 - 10'd106 : t2;
    t4 = t3 >= 10'd53 ? t3 - 10'd53 : t3;
    r_next = t4[5:0];
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= ACC;
    else state <= state_next;
  always_comb
    state_next = state == ACC ? (acc && frame_end ? HOLD : ACC) : (out_ready ? ACC : HOLD);
  always_comb begin
    in_ready = state == ACC;
    out_valid = state == HOLD;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r <= '0;
      cnt <= '0;
      out_res <= '0;
      out_err <= 1'b0;
    end else if (acc) begin
      r <= r_next;
      cnt <= frame_end ? 8'd0 : cnt + 8'd1;
      if (frame_end) begin
        out_res <= r_next;
        out_err <= in_last ^ at_end;
      end
    end else if (state == HOLD && out_ready) begin
      r <= '0;
    end
endmodule

// File: tb/tb_mod53_horner_reduce.sv
// tb_mod53_horner_reduce: directed + random frames on NUM_CHUNKS = 2, 84 and 1 instances
module tb_mod53_horner_reduce;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] in_data = '0;
  logic in_last = 1'b0;
  logic in_valid [3];
  logic out_ready [3];
  logic in_ready [3];
  logic out_valid [3];
  logic out_err [3];
  logic [5:0] out_res [3];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mod53_horner_reduce #(.NUM_CHUNKS(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_res(out_res[0]), .out_err(out_err[0]));
  mod53_horner_reduce #(.NUM_CHUNKS(84)) u_n84 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_res(out_res[1]), .out_err(out_err[1]));
  mod53_horner_reduce #(.NUM_CHUNKS(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_res(out_res[2]), .out_err(out_err[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Big-integer value mod 53 as sum of chunk * 64^k, k counted from the least-significant chunk.
  function automatic int ref_mod(input int q[$]);
    int s = 0;
    int pw = 1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      s = (s + q[i] * pw) % 53;
      pw = pw * 64 % 53;
    end
    return s;
  endfunction

  task automatic put(input int sel, input int d, input bit l, input bit gaps);
    int k = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid[sel] = 1'b1;
    in_data = d[5:0];
    in_last = l;
    while (!in_ready[sel] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready[sel]) chk("accept_timeout", int'(in_ready[sel]), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid[sel] = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send(input int sel, input int q[$], input bit last_flag, input bit gaps);
    for (int i = 0; i < q.size(); i++) put(sel, q[i], last_flag && i == q.size() - 1, gaps);
  endtask

  task automatic result(input int sel, input int er, input int ee, input string tag, input bit gaps);
    int k = 0;
    while (!out_valid[sel] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid[sel]) chk({tag, "_valid_timeout"}, int'(out_valid[sel]), 1);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    chk({tag, "_res"}, int'(out_res[sel]), er);
    chk({tag, "_err"}, int'(out_err[sel]), ee);
    out_ready[sel] = 1'b1;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    chk({tag, "_ready_after"}, int'(in_ready[sel]), 1);
  endtask

  initial begin
    int q[$];
    int held;
    int len;
    bit lf;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", int'(out_valid[0]), 0);
    chk("rst_ready", int'(in_ready[0]), 1);
    chk("rst_res", int'(out_res[0]), 0);
    chk("rst_err", int'(out_err[0]), 0);

    send(0, '{1, 0}, 1, 0);
    chk("t1_latency", int'(out_valid[0]), 1);
    chk("t1_hold_ready", int'(in_ready[0]), 0);
    result(0, 11, 0, "t1", 0);
    send(0, '{63, 63}, 1, 0);
    result(0, 14, 0, "t63", 0);
    send(0, '{0, 53}, 1, 0);
    result(0, 0, 0, "t53", 0);

    send(0, '{5}, 1, 0);
    result(0, 5, 1, "short", 0);
    send(0, '{1, 0}, 0, 0);
    result(0, 11, 1, "force", 0);
    send(0, '{5, 7}, 1, 0);
    result(0, ref_mod('{5, 7}), 0, "after_force", 0);

    q = {};
    repeat (84) q.push_back(63);
    send(1, q, 1, 0);
    result(1, 35, 0, "all63", 0);
    q = {};
    repeat (84) q.push_back(int'($urandom_range(0, 63)));
    send(1, q, 1, 0);
    result(1, ref_mod(q), 0, "rand84", 0);

    send(2, '{60}, 1, 0);
    result(2, 7, 0, "n1", 0);

    send(0, '{3, 4}, 1, 0);
    chk("bp_res0", int'(out_res[0]), ref_mod('{3, 4}));
    held = int'(out_res[0]);
    in_valid[0] = 1'b1;
    in_data = 6'd9;
    in_last = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid[0]), 1);
      chk("bp_stable", int'(out_res[0]), held);
      chk("bp_ready", int'(in_ready[0]), 0);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("bp_release", int'(in_ready[0]), 1);
    put(0, 9, 0, 0);
    put(0, 20, 1, 0);
    result(0, ref_mod('{9, 20}), 0, "bp_next", 0);

    for (int f = 0; f < 6; f++) begin
      lf = f != 5;
      len = lf ? int'($urandom_range(1, 84)) : 84;
      q = {};
      repeat (len) q.push_back(int'($urandom_range(0, 63)));
      send(1, q, lf, 1);
      result(1, ref_mod(q), (len != 84 || !lf) ? 1 : 0, "gaps", 1);
    end

    send(1, '{7, 8, 9}, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_valid", int'(out_valid[1]), 0);
    chk("abort_ready", int'(in_ready[1]), 1);
    q = {};
    repeat (84) q.push_back(int'($urandom_range(0, 63)));
    send(1, q, 1, 0);
    result(1, ref_mod(q), 0, "after_abort", 0);

    send(0, '{2, 2}, 1, 0);
    chk("hold_valid", int'(out_valid[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("hold_rst_valid", int'(out_valid[0]), 0);
    chk("hold_rst_res", int'(out_res[0]), 0);
    chk("hold_rst_ready", int'(in_ready[0]), 1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
